// File: rtl/median_window_3x3.sv
// Streaming 3x3 neighbourhood generator feeding a 9-input median sorter.
// Two line buffers plus a 3x3 shift window; one registered window per interior pixel.
module median_window_3x3 #(
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned IMG_WIDTH  = 640,
  parameter int unsigned IMG_HEIGHT = 480
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_sof,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_last,
  output logic [DATA_W-1:0] data_0,
  output logic [DATA_W-1:0] data_1,
  output logic [DATA_W-1:0] data_2,
  output logic [DATA_W-1:0] data_3,
  output logic [DATA_W-1:0] data_4,
  output logic [DATA_W-1:0] data_5,
  output logic [DATA_W-1:0] data_6,
  output logic [DATA_W-1:0] data_7,
  output logic [DATA_W-1:0] data_8
);

  localparam int unsigned COL_W = $clog2(IMG_WIDTH);
  localparam int unsigned ROW_W = $clog2(IMG_HEIGHT);
  localparam int unsigned WIN_N = 9;
  localparam logic [COL_W-1:0] COL_LAST = COL_W'(IMG_WIDTH - 1);
  localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(IMG_HEIGHT - 1);

  logic [COL_W-1:0]  col, col_eff, col_nxt;
  logic [ROW_W-1:0]  row, row_eff, row_nxt;
  logic              accept;
  logic              emit;
  logic              last_pix;
  logic [DATA_W-1:0] lb0_rd, lb1_rd;
  logic [DATA_W-1:0] lb0 [IMG_WIDTH];
  logic [DATA_W-1:0] lb1 [IMG_WIDTH];
  logic [DATA_W-1:0] win     [WIN_N];
  logic [DATA_W-1:0] win_nxt [WIN_N];
  logic [DATA_W-1:0] data_q  [WIN_N];

  // A start-of-frame beat is treated as (0,0) regardless of where the counters are.
  always_comb begin
    col_eff = in_sof ? '0 : col;
    row_eff = in_sof ? '0 : row;
  end

  assign in_ready = !out_valid || out_ready;
  assign accept   = in_valid && in_ready;
  assign emit     = accept && (row_eff >= ROW_W'(2)) && (col_eff >= COL_W'(2));
  assign last_pix = (row_eff == ROW_LAST) && (col_eff == COL_LAST);

  assign lb0_rd = lb0[col_eff];
  assign lb1_rd = lb1[col_eff];

  // Raster counters: column wraps into the next row, row wraps at end of frame.
  always_comb begin
    col_nxt = col_eff + COL_W'(1);
    row_nxt = row_eff;
    if (col_eff == COL_LAST) begin
      col_nxt = '0;
      row_nxt = (row_eff == ROW_LAST) ? '0 : row_eff + ROW_W'(1);
    end
  end

  // Shift window left; new right column is {row-2, row-1, row} at this column.
  always_comb begin
    for (int r = 0; r < 3; r++) begin
      win_nxt[r*3]     = win[r*3 + 1];
      win_nxt[r*3 + 1] = win[r*3 + 2];
    end
    win_nxt[2] = lb0_rd;
    win_nxt[5] = lb1_rd;
    win_nxt[8] = in_data;
  end

  // Line buffers are read-before-write at the same column and are never cleared.
  always_ff @(posedge clk) begin
    if (accept) begin
      lb0[col_eff] <= lb1_rd;
      lb1[col_eff] <= in_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      col       <= '0;
      row       <= '0;
      out_valid <= 1'b0;
      out_last  <= 1'b0;
      for (int i = 0; i < WIN_N; i++) begin
        win[i]    <= '0;
        data_q[i] <= '0;
      end
    end else begin
      if (accept) begin
        col <= col_nxt;
        row <= row_nxt;
        for (int i = 0; i < WIN_N; i++) win[i] <= win_nxt[i];
      end
      if (emit) begin
        out_valid <= 1'b1;
        out_last  <= last_pix;
        for (int i = 0; i < WIN_N; i++) data_q[i] <= win_nxt[i];
      end else if (out_ready) begin
        out_valid <= 1'b0;
        out_last  <= 1'b0;
      end
    end
  end

  assign data_0 = data_q[0];
  assign data_1 = data_q[1];
  assign data_2 = data_q[2];
  assign data_3 = data_q[3];
  assign data_4 = data_q[4];
  assign data_5 = data_q[5];
  assign data_6 = data_q[6];
  assign data_7 = data_q[7];
  assign data_8 = data_q[8];

endmodule
